// File: rtl/priority_encoder_seq.sv
// Sequential 4-input priority encoder: captures a multi-hot request set, then serves one index
// per consumer handshake in priority order. Define ENC_COUNT_EN to add the CNT pending-count port.
module priority_encoder_seq #(
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       E,
   input  logic       I0,
   input  logic       I1,
   input  logic       I2,
   input  logic       I3,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       A1,
   output logic       A0,
`ifdef ENC_COUNT_EN
   output logic       busy,
   output logic [2:0] CNT
`else
   output logic       busy
`endif
);

   typedef enum logic [0:0] {StIdle, StServe} state_e;

   state_e     state_q, state_d;
   logic [3:0] p_q, p_d;
   logic [3:0] req;
   logic [3:0] sel_onehot;
   logic [1:0] sel_idx;

   assign req = {I3, I2, I1, I0};

   // Selection looks only at registered P so the index never depends on the inputs.
   always_comb begin
      sel_idx    = 2'd0;
      sel_onehot = 4'b0000;
      if (LSB_FIRST) begin
         if (p_q[0]) begin
            sel_idx = 2'd0; sel_onehot = 4'b0001;
         end else if (p_q[1]) begin
            sel_idx = 2'd1; sel_onehot = 4'b0010;
         end else if (p_q[2]) begin
            sel_idx = 2'd2; sel_onehot = 4'b0100;
         end else if (p_q[3]) begin
            sel_idx = 2'd3; sel_onehot = 4'b1000;
         end
      end else begin
         if (p_q[3]) begin
            sel_idx = 2'd3; sel_onehot = 4'b1000;
         end else if (p_q[2]) begin
            sel_idx = 2'd2; sel_onehot = 4'b0100;
         end else if (p_q[1]) begin
            sel_idx = 2'd1; sel_onehot = 4'b0010;
         end else if (p_q[0]) begin
            sel_idx = 2'd0; sel_onehot = 4'b0001;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      p_d       = p_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      {A1, A0}  = 2'b00;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (E && (req != 4'b0000)) begin
               p_d     = req;
               state_d = StServe;
            end
         end
         StServe: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            {A1, A0}  = sel_idx;
            if (out_ready) begin
               p_d = p_q & ~sel_onehot;
               if (p_d == 4'b0000) begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
            p_d     = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         p_q     <= 4'b0000;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
      end
   end

`ifdef ENC_COUNT_EN
   // P is always zero in IDLE, so the popcount alone covers the idle/reset value.
   assign CNT = {2'b00, p_q[0]} + {2'b00, p_q[1]} + {2'b00, p_q[2]} + {2'b00, p_q[3]};
`endif

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Directed bench for priority_encoder_seq: one MSB-first and one LSB-first instance share stimulus.
module tb_priority_encoder_seq;

   logic clk = 1'b0;
   logic rst_n, e, i0, i1, i2, i3, out_ready;
   logic in_ready_m, out_valid_m, a1_m, a0_m, busy_m;
   logic in_ready_l, out_valid_l, a1_l, a0_l, busy_l;
`ifdef ENC_COUNT_EN
   logic [2:0] cnt_m, cnt_l;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   priority_encoder_seq #(.LSB_FIRST(1'b0)) dut_m (
      .clk(clk), .rst_n(rst_n), .E(e), .I0(i0), .I1(i1), .I2(i2), .I3(i3),
      .in_ready(in_ready_m), .out_valid(out_valid_m), .out_ready(out_ready),
      .A1(a1_m), .A0(a0_m),
`ifdef ENC_COUNT_EN
      .busy(busy_m), .CNT(cnt_m)
`else
      .busy(busy_m)
`endif
   );

   priority_encoder_seq #(.LSB_FIRST(1'b1)) dut_l (
      .clk(clk), .rst_n(rst_n), .E(e), .I0(i0), .I1(i1), .I2(i2), .I3(i3),
      .in_ready(in_ready_l), .out_valid(out_valid_l), .out_ready(out_ready),
      .A1(a1_l), .A0(a0_l),
`ifdef ENC_COUNT_EN
      .busy(busy_l), .CNT(cnt_l)
`else
      .busy(busy_l)
`endif
   );

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   // status = {in_ready, out_valid, busy}
   task automatic chk_m(input string tag, input logic [2:0] st, input logic [1:0] a);
      chk({tag, " m.status"}, {1'b0, in_ready_m, out_valid_m, busy_m}, {1'b0, st});
      chk({tag, " m.index"}, {2'b00, a1_m, a0_m}, {2'b00, a});
   endtask

   task automatic chk_l(input string tag, input logic [2:0] st, input logic [1:0] a);
      chk({tag, " l.status"}, {1'b0, in_ready_l, out_valid_l, busy_l}, {1'b0, st});
      chk({tag, " l.index"}, {2'b00, a1_l, a0_l}, {2'b00, a});
   endtask

   task automatic cnt_chk(input string tag, input logic [2:0] exp);
`ifdef ENC_COUNT_EN
      chk({tag, " m.cnt"}, {1'b0, cnt_m}, {1'b0, exp});
      chk({tag, " l.cnt"}, {1'b0, cnt_l}, {1'b0, exp});
`endif
   endtask

   task automatic set_req(input logic en, input logic [3:0] r);
      e = en;
      {i3, i2, i1, i0} = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [2:0] Idle  = 3'b100;
   localparam logic [2:0] Serve = 3'b011;

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b0;
      set_req(1'b0, 4'b0000);
      #2;
      chk_m("reset", Idle, 2'b00);
      chk_l("reset", Idle, 2'b00);
      cnt_chk("reset", 3'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // Single request I2, MSB-first and LSB-first agree on index 2.
      set_req(1'b1, 4'b0100);
      out_ready = 1'b1;
      tick();
      set_req(1'b0, 4'b0000);
      chk_m("single", Serve, 2'b10);
      chk_l("single", Serve, 2'b10);
      tick();
      chk_m("single done", Idle, 2'b00);
      chk_l("single done", Idle, 2'b00);

      // Multi-hot 1011.
      set_req(1'b1, 4'b1011);
      tick();
      set_req(1'b0, 4'b0000);
      chk_m("multi 1", Serve, 2'b11);
      chk_l("multi 1", Serve, 2'b00);
      cnt_chk("multi 1", 3'd3);
      tick();
      chk_m("multi 2", Serve, 2'b01);
      chk_l("multi 2", Serve, 2'b01);
      cnt_chk("multi 2", 3'd2);
      tick();
      chk_m("multi 3", Serve, 2'b00);
      chk_l("multi 3", Serve, 2'b11);
      cnt_chk("multi 3", 3'd1);
      // Request during the last serve cycle is ignored, then captured back-to-back in IDLE.
      set_req(1'b1, 4'b1000);
      tick();
      chk_m("multi done", Idle, 2'b00);
      chk_l("multi done", Idle, 2'b00);
      cnt_chk("multi done", 3'd0);
      tick();
      set_req(1'b0, 4'b0000);
      chk_m("b2b", Serve, 2'b11);
      chk_l("b2b", Serve, 2'b11);
      tick();
      chk_m("b2b done", Idle, 2'b00);

      // Backpressure on 0011.
      out_ready = 1'b0;
      set_req(1'b1, 4'b0011);
      tick();
      set_req(1'b0, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         chk_m("hold", Serve, 2'b01);
         chk_l("hold", Serve, 2'b00);
         cnt_chk("hold", 3'd2);
         tick();
      end
      out_ready = 1'b1;
      chk_m("release", Serve, 2'b01);
      tick();
      chk_m("release 2", Serve, 2'b00);
      chk_l("release 2", Serve, 2'b01);
      tick();
      chk_m("release done", Idle, 2'b00);

      // Empty strobe is ignored.
      set_req(1'b1, 4'b0000);
      tick();
      chk_m("empty", Idle, 2'b00);
      chk_l("empty", Idle, 2'b00);

      // Inputs ignored in SERVE.
      out_ready = 1'b0;
      set_req(1'b1, 4'b0101);
      tick();
      set_req(1'b1, 4'b1111);
      tick();
      tick();
      chk_m("ignore", Serve, 2'b10);
      chk_l("ignore", Serve, 2'b00);
      cnt_chk("ignore", 3'd2);
      set_req(1'b0, 4'b0000);
      out_ready = 1'b1;
      tick();
      chk_m("ignore 2", Serve, 2'b00);
      chk_l("ignore 2", Serve, 2'b10);
      tick();
      chk_m("ignore done", Idle, 2'b00);
      chk_l("ignore done", Idle, 2'b00);

      // 0111 walks the count down 3, 2, 1, 0.
      set_req(1'b1, 4'b0111);
      tick();
      set_req(1'b0, 4'b0000);
      chk_m("cnt 1", Serve, 2'b10);
      cnt_chk("cnt 1", 3'd3);
      tick();
      chk_m("cnt 2", Serve, 2'b01);
      cnt_chk("cnt 2", 3'd2);
      tick();
      chk_m("cnt 3", Serve, 2'b00);
      cnt_chk("cnt 3", 3'd1);
      tick();
      chk_m("cnt done", Idle, 2'b00);
      cnt_chk("cnt done", 3'd0);

      // Asynchronous reset mid-serve.
      set_req(1'b1, 4'b1111);
      tick();
      set_req(1'b0, 4'b0000);
      chk_m("rst pre", Serve, 2'b11);
      tick();
      chk_m("rst pre 2", Serve, 2'b10);
      chk_l("rst pre 2", Serve, 2'b01);
      #2;
      rst_n = 1'b0;
      #1;
      chk_m("async rst", Idle, 2'b00);
      chk_l("async rst", Idle, 2'b00);
      cnt_chk("async rst", 3'd0);
      tick();
      #2;
      rst_n = 1'b1;
      // First capture at the first edge after release.
      set_req(1'b1, 4'b0001);
      tick();
      set_req(1'b0, 4'b0000);
      chk_m("post rst", Serve, 2'b00);
      chk_l("post rst", Serve, 2'b00);
      cnt_chk("post rst", 3'd1);
      tick();
      chk_m("post rst done", Idle, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/priority_encoder_seq.md
PRIORITY_ENCODER_SEQ -- requirements
Module: priority_encoder_seq

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 0: 0 gives I3 the highest priority, 1 gives I0 the highest priority.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with the port list below in this order.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 E  input  1  capture strobe; sampled only while in_ready=1.
REQ-006 I0, I1, I2, I3  input  1 each  request bits, multi-hot allowed.
REQ-007 in_ready  output  1  high when the block can capture a new request set.
REQ-008 out_valid  output  1  high when A1:A0 holds a valid encoded index.
REQ-009 out_ready  input  1  consumer accepts the current index.
REQ-010 A1, A0  output  1 each  encoded index of the served request (A1 is the MSB).
REQ-011 busy  output  1  high while any captured request remains unserved.

Function
REQ-012 The block SHALL have two states: IDLE and SERVE.
REQ-013 It SHALL hold a 4-bit pending register P.
REQ-014 In IDLE: in_ready=1, out_valid=0, busy=0, A1:A0=00.
REQ-015 In IDLE with E=1 and any Ii=1 at a rising edge: P<={I3,I2,I1,I0} and the state goes to SERVE. out_valid SHALL be 1 from the next cycle (1-cycle latency).
REQ-016 In IDLE with E=1 and all Ii=0: no capture, state stays IDLE, no output activity.
REQ-017 In SERVE: in_ready=0, out_valid=1, busy=1.
REQ-018 In SERVE, A1:A0 SHALL be the index of the highest-priority set bit of P per LSB_FIRST, decoded only from registered P (no input paths).
REQ-019 In SERVE with out_ready=1 at a rising edge: the served bit of P SHALL clear. If P becomes 0000, the state SHALL go to IDLE and in_ready=1 in the next cycle; otherwise the next index SHALL be presented in the next cycle.
REQ-020 In SERVE with out_ready=0: P, A1:A0 and out_valid SHALL hold stable.
REQ-021 E and Ii SHALL be ignored in SERVE; requests arriving then are lost. Back-to-back capture SHALL be possible one cycle after the final accept.
REQ-022 A capture of k set bits SHALL produce exactly k handshakes, each index exactly once, in strict priority order.

Reset
REQ-023 While rst_n=0, regardless of clk: state=IDLE, P=0000, in_ready=1, out_valid=0, busy=0, A1:A0=00.
REQ-024 Reset asserted mid-SERVE SHALL discard all pending requests immediately.
REQ-025 The first capture SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-026 With macro ENC_COUNT_EN defined, the block SHALL add output port CNT  output  3  equal to popcount(P): 0 in IDLE and after reset, decremented on each accept.
REQ-027 With ENC_COUNT_EN undefined, CNT SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Single request, LSB_FIRST=0: E=1, I=0100 (I2 set), out_ready=1 -> one cycle later out_valid=1 with A1:A0=10; the next cycle in_ready=1 and out_valid=0.
REQ-029 Multi-hot, LSB_FIRST=0: I=1011, out_ready=1 -> A1:A0 sequence 11, 01, 00 over three consecutive cycles, then IDLE. With LSB_FIRST=1 the same input gives 00, 01, 11.
REQ-030 Backpressure: I=0011 captured, out_ready=0 for 5 cycles -> A1:A0=01 and out_valid=1 held for 5 cycles; then out_ready=1 gives 01 then 00.
REQ-031 Ignore cases: E=1 with I=0000 -> stays IDLE. E=1, I=1111 applied during SERVE -> P unaffected.
REQ-032 Reset mid-serve: I=1111 captured, one index accepted, then rst_n=0 asynchronously between edges -> out_valid=0, busy=0, in_ready=1 immediately.
REQ-033 With ENC_COUNT_EN: capture of I=0111 -> CNT sequence 3, 2, 1, 0 across the accepts.
